booth_mult_seq: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier; successor of the fixed 23-bit Booth core in the FP multiply path.
- Adds a start/busy/done handshake, a generic operand width, and a runtime signed/unsigned mode.
- Sits between the operand registers and the normalisation stage; the FP multiplier instantiates it with W=24 (mantissa plus hidden bit), unsigned.

---
 rtl/booth_mult_seq_if.sv | 22 ++
 rtl/booth_mult_seq.sv | 113 +++++++++++
 tb/tb_booth_mult_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
interface booth_mult_seq_if #(
  parameter int W = 24
);
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, result
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, W x W -> 2W, signed or unsigned.
// Define BOOTH_EARLY_EXIT_EN to finish as soon as no add/sub remains.
module booth_mult_seq #(
  parameter int W = 24
) (
  input logic             clock,
  input logic             reset,
  booth_mult_seq_if.slave bus
);
  localparam int N  = W + 1;
  localparam int CW = $clog2(N + 1);
  localparam int RW = 2 * W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [N-1:0]   br, ac, qr;
  logic           q_1;
  logic [CW-1:0]  cnt;
  logic           busy, done;
  logic [RW-1:0]  result;

  logic [N-1:0]          sum;
  logic signed [2*N:0]   cat;
  logic signed [2*N:0]   nxt;
  logic [RW-1:0]         fin;
  logic                  last;

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;

  // One extra bit lets a single signed datapath cover unsigned operands.
  function automatic logic [N-1:0] ext(
    input logic [W-1:0] v,
    input logic         s
  );
    return {s & v[W-1], v};
  endfunction

  always_comb begin
    unique case ({qr[0], q_1})
      2'b10:   sum = ac - br;
      2'b01:   sum = ac + br;
      default: sum = ac;
    endcase
  end

  assign cat = {sum, qr, q_1};
  assign nxt = cat >>> 1;

`ifdef BOOTH_EARLY_EXIT_EN
  logic [CW-1:0]         left;
  logic [N-1:0]          mask;
  logic [N-1:0]          nqr;
  logic                  nq1;
  logic signed [2*N-1:0] aq;

  assign left = cnt - CW'(1);
  assign nqr  = nxt[N:1];
  assign nq1  = nxt[0];
  assign mask = ~({N{1'b1}} << left);
  // Remaining pairs all equal: only sign-extending shifts are left.
  assign last = nq1 ? &(nqr | ~mask)
                    : ~|(nqr & mask);
  assign aq   = nxt[2*N:1];
  assign fin  = RW'($signed(aq) >>> left);
`else
  assign last = (cnt == CW'(1));
  assign fin  = nxt[RW:1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      br     <= '0;
      ac     <= '0;
      qr     <= '0;
      q_1    <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            br    <= ext(bus.y, bus.signed_mode);
            qr    <= ext(bus.x, bus.signed_mode);
            ac    <= '0;
            q_1   <= 1'b0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ac  <= nxt[2*N:N+1];
          qr  <= nxt[N:1];
          q_1 <= nxt[0];
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= fin;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (W=8 and W=24).
module tb_booth_mult_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  booth_mult_seq_if #(.W(8))  b8 ();
  booth_mult_seq_if #(.W(24)) b24 ();

  booth_mult_seq #(.W(8)) u8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8)
  );

  booth_mult_seq #(.W(24)) u24 (
    .clock (clock),
    .reset (reset),
    .bus   (b24)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run8(
    input  logic        m,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] r,
    output int          cyc,
    output int          nb
  );
    @(negedge clock);
    b8.start = 1'b1;
    b8.signed_mode = m;
    b8.x = a;
    b8.y = b;
    @(posedge clock); #1;
    b8.start = 1'b0;
    cyc = 0;
    nb = 0;
    while (!b8.done && cyc < 40) begin
      if (b8.busy) nb++;
      @(posedge clock); #1;
      cyc++;
    end
    r = b8.result;
  endtask

  initial begin
    logic [15:0] r;
    logic [47:0] r24;
    int cyc, nb, seen;

    b8.start = 1'b0;
    b8.signed_mode = 1'b0;
    b8.x = '0;
    b8.y = '0;
    b24.start = 1'b0;
    b24.signed_mode = 1'b0;
    b24.x = '0;
    b24.y = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(b8.busy), 64'd0);
    check("rst_done", 64'(b8.done), 64'd0);
    check("rst_result", 64'(b8.result), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run8(1'b1, 8'hFD, 8'h05, r, cyc, nb);
    check("s_m3x5", 64'(r), 64'hFFF1);
`ifdef BOOTH_EARLY_EXIT_EN
    check("s_m3x5_lat", 64'(cyc <= 9), 64'd1);
    check("s_m3x5_busy", 64'(nb == cyc), 64'd1);
`else
    check("s_m3x5_lat", 64'(cyc), 64'd9);
    check("s_m3x5_busy", 64'(nb), 64'd9);
`endif

    run8(1'b0, 8'hFF, 8'hFF, r, cyc, nb);
    check("u_ffxff", 64'(r), 64'hFE01);
    run8(1'b1, 8'h80, 8'h80, r, cyc, nb);
    check("s_80x80", 64'(r), 64'h4000);

    // start held through busy, then accepted in the done cycle
    @(negedge clock);
    b8.start = 1'b1;
    b8.signed_mode = 1'b0;
    b8.x = 8'd4;
    b8.y = 8'd5;
    @(posedge clock); #1;
    b8.x = 8'd2;
    b8.y = 8'd3;
    cyc = 0;
    while (!b8.done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("hold_r1", 64'(b8.result), 64'h0014);
    @(posedge clock); #1;
    check("accept_busy", 64'(b8.busy), 64'd1);
    b8.start = 1'b0;
    @(posedge clock); #1;
    check("result_held", 64'(b8.result), 64'h0014);
    cyc = 0;
    while (!b8.done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("accept_r2", 64'(b8.result), 64'h0006);

    // asynchronous reset in cycle 4 of the run
    @(negedge clock);
    b8.start = 1'b1;
    b8.signed_mode = 1'b0;
    b8.x = 8'd5;
    b8.y = 8'd6;
    @(posedge clock); #1;
    b8.start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(b8.busy), 64'd0);
    check("arst_done", 64'(b8.done), 64'd0);
    check("arst_result", 64'(b8.result), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (b8.done) seen++;
    end
    check("arst_no_done", 64'(seen), 64'd0);
    run8(1'b0, 8'd7, 8'd9, r, cyc, nb);
    check("after_rst_7x9", 64'(r), 64'h003F);

    // default width, unsigned
    @(negedge clock);
    b24.start = 1'b1;
    b24.signed_mode = 1'b0;
    b24.x = 24'h800000;
    b24.y = 24'h800000;
    @(posedge clock); #1;
    b24.start = 1'b0;
    cyc = 0;
    while (!b24.done && cyc < 80) begin
      @(posedge clock); #1;
      cyc++;
    end
    r24 = b24.result;
    check("w24_result", 64'(r24), 64'h400000000000);
`ifdef BOOTH_EARLY_EXIT_EN
    check("w24_lat", 64'(cyc <= 25), 64'd1);
`else
    check("w24_lat", 64'(cyc), 64'd25);
`endif

    run8(1'b1, 8'h00, 8'h7F, r, cyc, nb);
    check("zero_x", 64'(r), 64'h0000);
`ifdef BOOTH_EARLY_EXIT_EN
    check("zero_x_lat", 64'(cyc), 64'd1);
`else
    check("zero_x_lat", 64'(cyc), 64'd9);
`endif
    run8(1'b1, 8'h01, 8'hFF, r, cyc, nb);
    check("one_x_m1", 64'(r), 64'hFFFF);
`ifdef BOOTH_EARLY_EXIT_EN
    check("one_x_m1_lat", 64'(cyc <= 2), 64'd1);
`else
    check("one_x_m1_lat", 64'(cyc), 64'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
